// File: rtl/seg_scan_display_if.sv
// Display-side signal bundle for seg_scan_display: BCD time, edit/expiry state in,
// multiplexed 7-segment drive out.
interface seg_scan_display_if;
    logic [7:0] min_i;
    logic [7:0] sec_i;
    logic [7:0] ms_10_i;
    logic [1:0] target;
    logic       time_out;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output min_i, sec_i, ms_10_i, target, time_out,
        input  an, seg, dp
    );

    modport slave (
        input  min_i, sec_i, ms_10_i, target, time_out,
        output an, seg, dp
    );
endinterface

// File: rtl/seg_scan_display.sv
// Six-digit multiplexed 7-segment scanner with per-frame input snapshot,
// edit-field blinking and expiry flashing.
module seg_scan_display #(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLINK_FRAMES = 50
) (
    input  logic              clk_core,
    input  logic              rst,
    seg_scan_display_if.slave disp
);
    localparam int unsigned SW = $clog2(SCAN_DIV);
    localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [SW-1:0] r_scan_cnt;
    logic [2:0]    r_digit_idx;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_on;

    logic [7:0]    r_min;
    logic [7:0]    r_sec;
    logic [7:0]    r_ms;
    logic [1:0]    r_target;
    logic          r_time_out;

    logic [5:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;

    logic          w_scan_wrap;
    logic          w_frame_end;
    logic [3:0]    w_nibble;
    logic [6:0]    w_seg;
    logic          w_dp;
    logic          w_blank;
    logic [5:0]    w_an;

    assign w_scan_wrap = (r_scan_cnt == SCAN_LAST);
    assign w_frame_end = w_scan_wrap && (r_digit_idx == 3'd5);

    always_ff @(posedge clk_core) begin
        if (rst) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= 3'd0;
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else begin
            r_scan_cnt <= w_scan_wrap ? '0 : r_scan_cnt + SW'(1);
            if (w_scan_wrap) begin
                r_digit_idx <= (r_digit_idx == 3'd5) ? 3'd0 : r_digit_idx + 3'd1;
            end
            if (w_frame_end) begin
                if (r_blink_cnt == BLINK_LAST) begin
                    r_blink_cnt <= '0;
                    r_blink_on  <= ~r_blink_on;
                end else begin
                    r_blink_cnt <= r_blink_cnt + BW'(1);
                end
            end
        end
    end

    // Display only ever reads this copy, refreshed between frames, so a frame is never torn.
    always_ff @(posedge clk_core) begin
        if (rst || w_frame_end) begin
            r_min      <= disp.min_i;
            r_sec      <= disp.sec_i;
            r_ms       <= disp.ms_10_i;
            r_target   <= disp.target;
            r_time_out <= disp.time_out;
        end
    end

    always_comb begin
        w_nibble = 4'h0;
        w_seg    = 7'h7F;
        w_dp     = 1'b1;
        w_blank  = 1'b0;
        w_an     = ~(6'b000001 << r_digit_idx);

        case (r_digit_idx)
            3'd0:    w_nibble = r_ms[3:0];
            3'd1:    w_nibble = r_ms[7:4];
            3'd2:    w_nibble = r_sec[3:0];
            3'd3:    w_nibble = r_sec[7:4];
            3'd4:    w_nibble = r_min[3:0];
            default: w_nibble = r_min[7:4];
        endcase

        case (w_nibble)
            4'd0:    w_seg = 7'h40;
            4'd1:    w_seg = 7'h79;
            4'd2:    w_seg = 7'h24;
            4'd3:    w_seg = 7'h30;
            4'd4:    w_seg = 7'h19;
            4'd5:    w_seg = 7'h12;
            4'd6:    w_seg = 7'h02;
            4'd7:    w_seg = 7'h78;
            4'd8:    w_seg = 7'h00;
            4'd9:    w_seg = 7'h10;
            default: w_seg = 7'h3F;
        endcase

        w_dp = ~((r_digit_idx == 3'd2) || (r_digit_idx == 3'd4));

        // Expiry flash takes priority over edit-field blinking.
        if (r_time_out) begin
            w_blank = ~r_blink_on;
        end else if (!r_blink_on) begin
            case (r_target)
                2'b00:   w_blank = (r_digit_idx <= 3'd1);
                2'b01:   w_blank = (r_digit_idx == 3'd2) || (r_digit_idx == 3'd3);
                2'b10:   w_blank = (r_digit_idx >= 3'd4);
                default: w_blank = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_core) begin
        if (rst) begin
            r_an  <= 6'h3F;
            r_seg <= 7'h7F;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an;
            r_seg <= w_blank ? 7'h7F : w_seg;
            r_dp  <= w_blank ? 1'b1 : w_dp;
        end
    end

    assign disp.an  = r_an;
    assign disp.seg = r_seg;
    assign disp.dp  = r_dp;
endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display at SCAN_DIV=4, BLINK_FRAMES=2: expected
// per-cycle {an,seg,dp} is queued as stimulus is set up and popped each cycle.
module tb_seg_scan_display;
    logic clk_core = 1'b0;
    logic rst      = 1'b1;

    seg_scan_display_if disp ();

    seg_scan_display #(
        .SCAN_DIV     (4),
        .BLINK_FRAMES (2)
    ) dut (
        .clk_core (clk_core),
        .rst      (rst),
        .disp     (disp)
    );

    always #5 clk_core = ~clk_core;

    logic [13:0] sb[$];
    logic [6:0]  seg_tbl[16];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    task automatic set_in(input logic [7:0] mn, input logic [7:0] sc, input logic [7:0] ms,
                          input logic [1:0] tg, input logic to);
        disp.min_i    = mn;
        disp.sec_i    = sc;
        disp.ms_10_i  = ms;
        disp.target   = tg;
        disp.time_out = to;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        sb.delete();
    endtask

    // One digit slot lasts SCAN_DIV = 4 cycles.
    task automatic push_slot(input int d, input logic [3:0] nib, input logic blank);
        logic [5:0]  a;
        logic [13:0] e;
        a    = 6'h3F;
        a[d] = 1'b0;
        if (blank) e = {a, 7'h7F, 1'b1};
        else       e = {a, seg_tbl[nib], ((d == 2) || (d == 4)) ? 1'b0 : 1'b1};
        repeat (4) sb.push_back(e);
    endtask

    task automatic push_frame(input logic [7:0] mn, input logic [7:0] sc, input logic [7:0] ms,
                              input logic [5:0] mask);
        push_slot(0, ms[3:0], mask[0]);
        push_slot(1, ms[7:4], mask[1]);
        push_slot(2, sc[3:0], mask[2]);
        push_slot(3, sc[7:4], mask[3]);
        push_slot(4, mn[3:0], mask[4]);
        push_slot(5, mn[7:4], mask[5]);
    endtask

    task automatic test_reset();
        logic [13:0] got;
        rst = 1'b1;
        set_in(8'h05, 8'h30, 8'h07, 2'b11, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            got = {disp.an, disp.seg, disp.dp};
            n_checks++;
            if (got !== {6'h3F, 7'h7F, 1'b1}) begin
                n_errors++;
                $display("FAIL reset[%0d]: got an=%h seg=%h dp=%b, expected an=3f seg=7f dp=1",
                         i, got[13:8], got[7:1], got[0]);
            end
        end
    endtask

    task automatic test_scan();
        logic [13:0] got, exp;
        set_in(8'h05, 8'h30, 8'h07, 2'b11, 1'b0);
        do_reset();
        // Frames 2-3 run with blink_on low; target 11 must still show everything.
        repeat (4) push_frame(8'h05, 8'h30, 8'h07, 6'b000000);
        for (int i = 0; i < 96; i++) begin
            tick();
            got = {disp.an, disp.seg, disp.dp};
            exp = (sb.size() != 0) ? sb.pop_front() : 14'h3FFF;
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL scan[%0d]: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                         i, got[13:8], got[7:1], got[0], exp[13:8], exp[7:1], exp[0]);
            end
        end
    endtask

    task automatic test_edit_blink();
        logic [13:0] got, exp;
        set_in(8'h12, 8'h34, 8'h56, 2'b01, 1'b0);
        do_reset();
        repeat (2) push_frame(8'h12, 8'h34, 8'h56, 6'b000000);
        repeat (2) push_frame(8'h12, 8'h34, 8'h56, 6'b001100);
        repeat (2) push_frame(8'h12, 8'h34, 8'h56, 6'b000000);
        for (int i = 0; i < 144; i++) begin
            tick();
            got = {disp.an, disp.seg, disp.dp};
            exp = (sb.size() != 0) ? sb.pop_front() : 14'h3FFF;
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL edit_blink[%0d]: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                         i, got[13:8], got[7:1], got[0], exp[13:8], exp[7:1], exp[0]);
            end
        end
    endtask

    task automatic test_expiry();
        logic [13:0] got, exp;
        set_in(8'h00, 8'h00, 8'h00, 2'b00, 1'b1);
        do_reset();
        repeat (2) push_frame(8'h00, 8'h00, 8'h00, 6'b000000);
        repeat (2) push_frame(8'h00, 8'h00, 8'h00, 6'b111111);
        repeat (2) push_frame(8'h00, 8'h00, 8'h00, 6'b000000);
        for (int i = 0; i < 144; i++) begin
            tick();
            got = {disp.an, disp.seg, disp.dp};
            exp = (sb.size() != 0) ? sb.pop_front() : 14'h3FFF;
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL expiry[%0d]: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                         i, got[13:8], got[7:1], got[0], exp[13:8], exp[7:1], exp[0]);
            end
        end
    endtask

    task automatic test_snapshot();
        logic [13:0] got, exp;
        set_in(8'h05, 8'h30, 8'h07, 2'b11, 1'b0);
        do_reset();
        push_frame(8'h05, 8'h30, 8'h07, 6'b000000);
        push_frame(8'h05, 8'h29, 8'h07, 6'b000000);
        for (int i = 0; i < 48; i++) begin
            // After 5 cycles the scanner's digit_idx is 1; change sec and target mid-frame.
            if (i == 5) set_in(8'h05, 8'h29, 8'h07, 2'b01, 1'b0);
            tick();
            got = {disp.an, disp.seg, disp.dp};
            exp = (sb.size() != 0) ? sb.pop_front() : 14'h3FFF;
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL snapshot[%0d]: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                         i, got[13:8], got[7:1], got[0], exp[13:8], exp[7:1], exp[0]);
            end
        end
    endtask

    task automatic test_dash();
        logic [13:0] got, exp;
        set_in(8'h98, 8'hB6, 8'h0A, 2'b11, 1'b0);
        do_reset();
        push_frame(8'h98, 8'hB6, 8'h0A, 6'b000000);
        for (int i = 0; i < 24; i++) begin
            tick();
            got = {disp.an, disp.seg, disp.dp};
            exp = (sb.size() != 0) ? sb.pop_front() : 14'h3FFF;
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL dash[%0d]: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                         i, got[13:8], got[7:1], got[0], exp[13:8], exp[7:1], exp[0]);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [13:0] got, exp;
        set_in(8'h21, 8'h43, 8'h65, 2'b01, 1'b0);
        do_reset();
        repeat (2) push_frame(8'h21, 8'h43, 8'h65, 6'b000000);
        push_slot(0, 4'h5, 1'b0);
        push_slot(1, 4'h6, 1'b0);
        push_slot(2, 4'h3, 1'b1);
        for (int i = 0; i < 60; i++) begin
            tick();
            got = {disp.an, disp.seg, disp.dp};
            exp = (sb.size() != 0) ? sb.pop_front() : 14'h3FFF;
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL mid_reset_pre[%0d]: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                         i, got[13:8], got[7:1], got[0], exp[13:8], exp[7:1], exp[0]);
            end
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL mid_reset_queue: got %0d pending, expected 0", sb.size());
        end
        // digit_idx is 3 and blink_on is low here; a one-cycle reset must clear both.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        got = {disp.an, disp.seg, disp.dp};
        n_checks++;
        if (got !== {6'h3F, 7'h7F, 1'b1}) begin
            n_errors++;
            $display("FAIL mid_reset_off: got an=%h seg=%h dp=%b, expected an=3f seg=7f dp=1",
                     got[13:8], got[7:1], got[0]);
        end
        repeat (2) push_frame(8'h21, 8'h43, 8'h65, 6'b000000);
        push_frame(8'h21, 8'h43, 8'h65, 6'b001100);
        for (int i = 0; i < 72; i++) begin
            tick();
            got = {disp.an, disp.seg, disp.dp};
            exp = (sb.size() != 0) ? sb.pop_front() : 14'h3FFF;
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL mid_reset_post[%0d]: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                         i, got[13:8], got[7:1], got[0], exp[13:8], exp[7:1], exp[0]);
            end
        end
    endtask

    initial begin
        seg_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        set_in(8'h00, 8'h00, 8'h00, 2'b11, 1'b0);
        test_reset();
        test_scan();
        test_edit_blink();
        test_expiry();
        test_snapshot();
        test_dash();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/seg_scan_display.md
SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 SHALL provide parameter SCAN_DIV, default 50000: clk_core cycles per digit slot (>=2).
REQ-002 SHALL provide parameter BLINK_FRAMES, default 50: full scan frames per blink half-period (>=1).
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk_core in 1, the rising-edge clock; rst in 1, reset.
REQ-004 SHALL have ports min_i in 8 (BCD minutes, [7:4] tens, [3:0] units), sec_i in 8 (BCD seconds), ms_10_i in 8 (BCD hundredths).
REQ-005 SHALL have ports target in 2 (00 hundredths, 01 seconds, 10 minutes selected for edit; 11 running) and time_out in 1 (countdown expired, level).
REQ-006 SHALL have outputs an out 6 (active-low digit enables, an[0] rightmost), seg out 7 (active-low, bit order gfedcba), dp out 1 (active-low decimal point).

Function
REQ-007 Digit map SHALL be: an[0] ms_10_i[3:0], an[1] ms_10_i[7:4], an[2] sec_i[3:0], an[3] sec_i[7:4], an[4] min_i[3:0], an[5] min_i[7:4].
REQ-008 scan_cnt SHALL count 0..SCAN_DIV-1 and wrap; digit_idx SHALL advance by one (5 wraps to 0) in the cycle scan_cnt wraps.
REQ-009 A frame SHALL be one full pass of digit_idx 0..5; frame end SHALL be the cycle digit_idx wraps from 5 to 0.
REQ-010 Snapshot registers for min/sec/ms_10/target/time_out SHALL load from the inputs at every frame end and in every cycle rst is high; the inputs SHALL NOT be used directly for display, so no frame shows torn data.
REQ-011 blink_cnt SHALL count frame ends 0..BLINK_FRAMES-1; on the frame end where blink_cnt = BLINK_FRAMES-1, blink_cnt SHALL wrap to 0 and blink_on SHALL toggle.
REQ-012 an, seg and dp SHALL be registered and SHALL reflect digit_idx and the snapshot of the previous cycle (1-cycle latency).
REQ-013 Exactly one an bit SHALL be low when not in reset: an[digit_idx].
REQ-014 Decoding, as seg hex: 0 40, 1 79, 2 24, 3 30, 4 19, 5 12, 6 02, 7 78, 8 00, 9 10; nibble >9 SHALL show a dash, 3F.
REQ-015 dp SHALL be 0 on digit 2 and digit 4, and 1 elsewhere, unless the digit is blanked.
REQ-016 Blanked digit SHALL drive seg = 7F and dp = 1, with an still scanning.
REQ-017 Edit blink: when snapshot target is in 00..10, time_out is 0 and blink_on is 0, the two digits of the selected field SHALL be blanked; other digits SHALL display normally.
REQ-018 target = 11 with time_out = 0 SHALL blank no digit, regardless of blink_on.
REQ-019 Expiry flash: snapshot time_out = 1 SHALL override target; all six digits SHALL be blanked while blink_on = 0 and shown while blink_on = 1.
REQ-020 Changes of target or time_out SHALL take effect at the next frame end only, never mid-frame.

Reset
REQ-021 While rst is high: scan_cnt = 0, digit_idx = 0, blink_cnt = 0, blink_on = 1, an = 3F (all off), seg = 7F, dp = 1, and snapshot = inputs.
REQ-022 In the first cycle after rst falls, outputs SHALL show digit 0 of the snapshot taken during reset.
REQ-023 rst asserted mid-frame or mid-blink SHALL apply REQ-021 on the next edge; no partial state SHALL survive.

Verification (SCAN_DIV=4, BLINK_FRAMES=2)
REQ-024 Inputs min=05, sec=30, ms=07, target=11, rst released -> an sequence 3E,3D,3B,37,2F,1F with 4 cycles each; seg 78,40,40,30,12,40; dp low on an=3B and an=2F.
REQ-025 target=01 held -> frames 0-1 show all digits; frames 2-3 have an=37/3B slots with seg=7F and dp=1; frames 4-5 show all digits again.
REQ-026 time_out=1 with target=00 -> every slot in frames 2-3 is blanked; frames 0-1 and 4-5 show the digits; target blinking is ignored.
REQ-027 sec_i changed from 30 to 29 while digit_idx=1 -> digits 2/3 of the current frame still show 30; the next frame shows 29.
REQ-028 ms_10_i=0A -> digit 0 seg=3F (dash), digit 1 seg=40.
REQ-029 rst pulsed for one cycle at digit_idx=3 -> the next cycle has an=3F; digit 0 is shown one cycle later, and the blink phase restarts visible.
